frame_compositor: RTL and testbench

//  Pixel-colour stage directly downstream of the VGA timing generator. Consumes DrawX/DrawY,
//  hs/vs/blank, composites sky, ground, one pipe pair and the bird sprite into 8-bit RGB,
//  and delays sync/blank so they stay aligned with colour. Snapshots game-object positions

---
 rtl/frame_pkg.sv | 71 +++++++
 rtl/bird_sprite_rom.sv | 42 ++++
 rtl/frame_compositor.sv | 210 +++++++++++++++++++++
 tb/tb_frame_compositor.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_pkg.sv
// -----------------------------------------------------------------------------
// frame_pkg
// Shared definitions for the frame compositor: screen and object geometry,
// the RGB colour type, fixed layer colours, the 16-entry bird palette, the
// layer enumeration and the bird sprite artwork (as a pure function of
// sprite row/column, so the sprite ROM needs no external image file).
// -----------------------------------------------------------------------------
package frame_pkg;

    localparam int unsigned H_ACTIVE  = 640;
    localparam int unsigned V_ACTIVE  = 480;
    localparam int unsigned GROUND_Y  = 432;
    localparam int unsigned PIPE_W    = 52;
    localparam int unsigned GAP_H     = 120;
    localparam int unsigned BIRD_X    = 160;
    localparam int unsigned BIRD_W    = 32;
    localparam int unsigned BIRD_H    = 24;

    // Sprite ROM geometry: 32x24 entries, addressed row*BIRD_W + col
    localparam int unsigned ROM_DEPTH = BIRD_W * BIRD_H;
    localparam int unsigned ROM_AW    = 10;

    // Width used for every hit-test compare so that sums never wrap
    localparam int unsigned CW        = 12;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        L_SKY    = 2'd0,
        L_GROUND = 2'd1,
        L_PIPE   = 2'd2,
        L_BIRD   = 2'd3
    } layer_e;

    localparam rgb_t BLACK_RGB  = 24'h000000;
    localparam rgb_t SKY_RGB    = 24'h70C5CE;
    localparam rgb_t GROUND_RGB = 24'hDED895;
    localparam rgb_t PIPE_RGB   = 24'h73BF2E;

    // Index 0 is transparent and never displayed; 1 eye, 2 beak, 3 wing, 4 body
    localparam rgb_t BIRD_PALETTE [16] = '{
        24'h000000, 24'hFFFFFF, 24'hF7A31C, 24'hD8A020,
        24'hF8D838, 24'h000000, 24'h000000, 24'h000000,
        24'h000000, 24'h000000, 24'h000000, 24'h000000,
        24'h000000, 24'h000000, 24'h000000, 24'h000000
    };

    // Bird artwork: rounded body with eye, beak and wing; border is transparent
    function automatic logic [3:0] bird_pixel(input logic [4:0] row, input logic [4:0] col);
        logic [3:0] idx;
        if ((row < 5'd2) || (row > 5'd21) || (col < 5'd2) || (col > 5'd29)) begin
            idx = 4'd0;
        end else if (((row < 5'd4) || (row > 5'd19)) && ((col < 5'd5) || (col > 5'd26))) begin
            idx = 4'd0;
        end else if ((row >= 5'd5) && (row <= 5'd8) && (col >= 5'd20) && (col <= 5'd23)) begin
            idx = 4'd1;
        end else if ((row >= 5'd10) && (row <= 5'd13) && (col >= 5'd24)) begin
            idx = 4'd2;
        end else if ((row >= 5'd12) && (row <= 5'd17) && (col >= 5'd6) && (col <= 5'd13)) begin
            idx = 4'd3;
        end else begin
            idx = 4'd4;
        end
        return idx;
    endfunction

endpackage

// File: rtl/bird_sprite_rom.sv
// -----------------------------------------------------------------------------
// bird_sprite_rom
// Synchronous BIRD_W*BIRD_H x 4-bit palette-index ROM for the bird sprite.
// Contents come from frame_pkg::bird_pixel; addresses past the sprite read 0.
// Ports:
//   Clk   in   system clock
//   ce    in   read enable; idx updates only when high
//   addr  in   row*BIRD_W + col
//   idx   out  registered palette index (0 = transparent)
// -----------------------------------------------------------------------------
module bird_sprite_rom
    import frame_pkg::*;
(
    input  logic              Clk,
    input  logic              ce,
    input  logic [ROM_AW-1:0] addr,
    output logic [3:0]        idx
);

    localparam int unsigned SLOTS = 32'd1 << ROM_AW;

    logic [3:0] rom_s [SLOTS];
    logic [3:0] idx_q;

    for (genvar a = 0; a < SLOTS; a++) begin : g_rom
        if (a < ROM_DEPTH) begin : g_art
            assign rom_s[a] = bird_pixel(5'(a / BIRD_W), 5'(a % BIRD_W));
        end else begin : g_pad
            assign rom_s[a] = 4'd0;
        end
    end

    // Registered read; no reset because the consumer qualifies idx with its own flag
    always_ff @(posedge Clk) begin
        if (ce) begin
            idx_q <= rom_s[addr];
        end
    end

    assign idx = idx_q;

endmodule

// File: rtl/frame_compositor.sv
// -----------------------------------------------------------------------------
// frame_compositor
// Pixel-colour stage behind the VGA timing generator. Composites sky, ground,
// one pipe pair and the bird sprite into 8-bit RGB with a 2-beat pipeline and
// delays hs/vs/blank by the same amount. Object positions are snapshotted
// once per frame at (0, V_ACTIVE) so a frame never tears.
// Optional build macro: COMPOSITOR_GRID_EN draws a white 32-px grid over sky.
// Ports:
//   Clk, Reset            clock, synchronous active-high reset
//   pixel_ce              beat enable; all state except Reset advances on it
//   DrawX, DrawY          current coordinate
//   hs_in, vs_in          active-low syncs;  blank_in 1 = visible
//   bird_y, pipe_x, gap_y live object positions
//   VGA_R, VGA_G, VGA_B   colour output
//   hs_out, vs_out        syncs delayed 2 beats;  blank_out blank delayed 2 beats
//   frame_tick            one-Clk pulse when shadow positions load
// -----------------------------------------------------------------------------
module frame_compositor
    import frame_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic        pixel_ce,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        hs_in,
    input  logic        vs_in,
    input  logic        blank_in,
    input  logic [9:0]  bird_y,
    input  logic [10:0] pipe_x,
    input  logic [9:0]  gap_y,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B,
    output logic        hs_out,
    output logic        vs_out,
    output logic        blank_out,
    output logic        frame_tick
);

    // Shadow object positions used for the frame being drawn
    logic [9:0]        bird_y_q;
    logic [10:0]       pipe_x_q;
    logic [9:0]        gap_y_q;
    logic              snap_s;
    logic              frame_tick_q;

    // Stage 1
    logic [CW-1:0]     x_s, y_s, by_s, px_s, gy_s, row_s, col_s;
    logic              pipe_hit_d, ground_hit_d, bird_box_d;
    logic [ROM_AW-1:0] rom_addr_d;
    logic              hs1_q, vs1_q, blank1_q, pipe1_q, ground1_q, bird1_q;
    logic [3:0]        sprite_idx_s;

    // Stage 2
    layer_e            layer_s;
    rgb_t              layer_rgb_s;
    rgb_t              rgb_d, rgb_q;
    logic              hs2_q, vs2_q, blank2_q;

`ifdef COMPOSITOR_GRID_EN
    localparam rgb_t GRID_RGB = 24'hFFFFFF;
    logic              grid_d, grid1_q;
`endif

    // Zero-extend everything to CW bits so x+W / y+H sums cannot wrap
    assign x_s  = {2'b00, DrawX};
    assign y_s  = {2'b00, DrawY};
    assign by_s = {2'b00, bird_y_q};
    assign px_s = {1'b0, pipe_x_q};
    assign gy_s = {2'b00, gap_y_q};

    // First pixel of the first non-visible line
    assign snap_s = pixel_ce && (DrawX == 10'd0) && (DrawY == 10'(V_ACTIVE));

    // Stage-1 hit tests and sprite ROM address
    always_comb begin
        pipe_hit_d   = 1'b0;
        ground_hit_d = 1'b0;
        bird_box_d   = 1'b0;
        rom_addr_d   = {ROM_AW{1'b0}};
        row_s        = y_s - by_s;
        col_s        = x_s - CW'(BIRD_X);
        pipe_hit_d   = (x_s >= px_s) && (x_s < (px_s + CW'(PIPE_W))) &&
                       !((y_s >= gy_s) && (y_s < (gy_s + CW'(GAP_H))));
        ground_hit_d = (y_s >= CW'(GROUND_Y));
        bird_box_d   = (x_s >= CW'(BIRD_X)) && (x_s < CW'(BIRD_X + BIRD_W)) &&
                       (y_s >= by_s) && (y_s < (by_s + CW'(BIRD_H)));
        if (bird_box_d) begin
            rom_addr_d = ROM_AW'((row_s * CW'(BIRD_W)) + col_s);
        end else begin
            rom_addr_d = {ROM_AW{1'b0}};
        end
    end

`ifdef COMPOSITOR_GRID_EN
    assign grid_d = (DrawX[4:0] == 5'd0) || (DrawY[4:0] == 5'd0);
`endif

    bird_sprite_rom u_rom (
        .Clk  (Clk),
        .ce   (pixel_ce),
        .addr (rom_addr_d),
        .idx  (sprite_idx_s)
    );

    // Shadow registers; live values presented on the snapshot beat are taken
    always_ff @(posedge Clk) begin
        if (Reset) begin
            bird_y_q <= 10'd240;
            pipe_x_q <= 11'(H_ACTIVE);
            gap_y_q  <= 10'd160;
        end else if (snap_s) begin
            bird_y_q <= bird_y;
            pipe_x_q <= pipe_x;
            gap_y_q  <= gap_y;
        end
    end

    // frame_tick follows every Clk so the pulse lasts exactly one Clk
    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_tick_q <= 1'b0;
        end else begin
            frame_tick_q <= snap_s;
        end
    end

    // Stage-1 pipeline registers (sync and hit flags)
    always_ff @(posedge Clk) begin
        if (Reset) begin
            hs1_q     <= 1'b1;
            vs1_q     <= 1'b1;
            blank1_q  <= 1'b0;
            pipe1_q   <= 1'b0;
            ground1_q <= 1'b0;
            bird1_q   <= 1'b0;
        end else if (pixel_ce) begin
            hs1_q     <= hs_in;
            vs1_q     <= vs_in;
            blank1_q  <= blank_in;
            pipe1_q   <= pipe_hit_d;
            ground1_q <= ground_hit_d;
            bird1_q   <= bird_box_d;
        end
    end

`ifdef COMPOSITOR_GRID_EN
    // Stage-1 grid flag
    always_ff @(posedge Clk) begin
        if (Reset) begin
            grid1_q <= 1'b0;
        end else if (pixel_ce) begin
            grid1_q <= grid_d;
        end
    end
`endif

    // Stage-2 layer priority: opaque bird > pipe > ground > sky, then blanking
    always_comb begin
        layer_s     = L_SKY;
        layer_rgb_s = SKY_RGB;
        rgb_d       = BLACK_RGB;
        if (bird1_q && (sprite_idx_s != 4'd0)) begin
            layer_s = L_BIRD;
        end else if (pipe1_q) begin
            layer_s = L_PIPE;
        end else if (ground1_q) begin
            layer_s = L_GROUND;
        end else begin
            layer_s = L_SKY;
        end
        case (layer_s)
            L_BIRD:   layer_rgb_s = BIRD_PALETTE[sprite_idx_s];
            L_PIPE:   layer_rgb_s = PIPE_RGB;
            L_GROUND: layer_rgb_s = GROUND_RGB;
`ifdef COMPOSITOR_GRID_EN
            L_SKY:    layer_rgb_s = grid1_q ? GRID_RGB : SKY_RGB;
`else
            L_SKY:    layer_rgb_s = SKY_RGB;
`endif
            default:  layer_rgb_s = SKY_RGB;
        endcase
        rgb_d = blank1_q ? layer_rgb_s : BLACK_RGB;
    end

    // Stage-2 output registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rgb_q    <= BLACK_RGB;
            hs2_q    <= 1'b1;
            vs2_q    <= 1'b1;
            blank2_q <= 1'b0;
        end else if (pixel_ce) begin
            rgb_q    <= rgb_d;
            hs2_q    <= hs1_q;
            vs2_q    <= vs1_q;
            blank2_q <= blank1_q;
        end
    end

    assign VGA_R      = rgb_q.r;
    assign VGA_G      = rgb_q.g;
    assign VGA_B      = rgb_q.b;
    assign hs_out     = hs2_q;
    assign vs_out     = vs2_q;
    assign blank_out  = blank2_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_frame_compositor.sv
// -----------------------------------------------------------------------------
// tb_frame_compositor
// Self-checking bench for frame_compositor. A behavioural model computes each
// pixel's colour straight from the layer rules with integer arithmetic, keeps
// its own shadow positions, and delays results by two pixel_ce beats.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_frame_compositor;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        pixel_ce = 1'b0;
    logic [9:0]  DrawX = 10'd0;
    logic [9:0]  DrawY = 10'd0;
    logic        hs_in = 1'b1;
    logic        vs_in = 1'b1;
    logic        blank_in = 1'b0;
    logic [9:0]  bird_y = 10'd0;
    logic [10:0] pipe_x = 11'd0;
    logic [9:0]  gap_y = 10'd0;
    logic [7:0]  VGA_R, VGA_G, VGA_B;
    logic        hs_out, vs_out, blank_out, frame_tick;

    frame_compositor dut (
        .Clk(Clk), .Reset(Reset), .pixel_ce(pixel_ce),
        .DrawX(DrawX), .DrawY(DrawY),
        .hs_in(hs_in), .vs_in(vs_in), .blank_in(blank_in),
        .bird_y(bird_y), .pipe_x(pipe_x), .gap_y(gap_y),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .hs_out(hs_out), .vs_out(vs_out), .blank_out(blank_out),
        .frame_tick(frame_tick)
    );

    always #10 Clk = ~Clk;

    typedef struct packed {
        logic [23:0] rgb;
        logic        hs;
        logic        vs;
        logic        blank;
    } beat_t;

    localparam beat_t RST_BEAT = '{rgb: 24'h000000, hs: 1'b1, vs: 1'b1, blank: 1'b0};

    int    n_cmp = 0;
    int    n_fail = 0;
    beat_t e1, e2;
    logic  exp_tick;
    int    m_by, m_px, m_gy;

    logic [23:0] rgb_obs;
    logic [27:0] obs;
    assign rgb_obs = {VGA_R, VGA_G, VGA_B};
    assign obs     = {VGA_R, VGA_G, VGA_B, hs_out, vs_out, blank_out, frame_tick};

    // ---------------- reference model ----------------
    function automatic int sprite_model(int r, int c);
        if (r < 2 || r > 21 || c < 2 || c > 29) return 0;
        if ((r < 4 || r > 19) && (c < 5 || c > 26)) return 0;
        if (r >= 5 && r <= 8 && c >= 20 && c <= 23) return 1;
        if (r >= 10 && r <= 13 && c >= 24) return 2;
        if (r >= 12 && r <= 17 && c >= 6 && c <= 13) return 3;
        return 4;
    endfunction

    function automatic logic [23:0] pal_model(int idx);
        case (idx)
            1:       return 24'hFFFFFF;
            2:       return 24'hF7A31C;
            3:       return 24'hD8A020;
            4:       return 24'hF8D838;
            default: return 24'h000000;
        endcase
    endfunction

    function automatic logic [23:0] model_rgb(int x, int y, bit vis);
        int r, c, idx;
        if (!vis) return 24'h000000;
        r = y - m_by;
        c = x - 160;
        if (r >= 0 && r < 24 && c >= 0 && c < 32) begin
            idx = sprite_model(r, c);
            if (idx != 0) return pal_model(idx);
        end
        if (x >= m_px && x < m_px + 52 && (y < m_gy || y >= m_gy + 120)) return 24'h73BF2E;
        if (y >= 432) return 24'hDED895;
`ifdef COMPOSITOR_GRID_EN
        if (x % 32 == 0 || y % 32 == 0) return 24'hFFFFFF;
`endif
        return 24'h70C5CE;
    endfunction

    // Present one coordinate for one Clk and advance the model (no checking)
    task automatic drive(input int x, input int y, input bit vis, input bit ce);
        DrawX    = 10'(x);
        DrawY    = 10'(y);
        blank_in = vis;
        pixel_ce = ce;
        hs_in    = 1'($urandom_range(0, 1));
        vs_in    = 1'($urandom_range(0, 1));
        @(posedge Clk);
        #1;
        if (Reset) begin
            e1 = RST_BEAT; e2 = RST_BEAT; exp_tick = 1'b0;
            m_by = 240; m_px = 640; m_gy = 160;
        end else begin
            exp_tick = ce && (x == 0) && (y == 480);
            if (ce) begin
                e2 = e1;
                e1 = '{rgb: model_rgb(x, y, vis), hs: hs_in, vs: vs_in, blank: vis};
                if (exp_tick) begin
                    m_by = int'(bird_y); m_px = int'(pipe_x); m_gy = int'(gap_y);
                end
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        Reset = 1'b1;
        bird_y = 10'($urandom); pipe_x = 11'($urandom); gap_y = 10'($urandom);
        for (int i = 0; i < 3; i++) begin
            drive($urandom_range(0, 799), $urandom_range(0, 524), 1'b1, 1'($urandom_range(0, 1)));
            n_cmp++;
            if (obs !== {24'h000000, 1'b1, 1'b1, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL reset_state: got %h want %h", obs, {24'h000000, 4'b1100});
            end
        end
        Reset = 1'b0;
    endtask

    task automatic test_sky();
        logic h0, v0;
        drive(10, 10, 1'b1, 1'b1);
        h0 = hs_in; v0 = vs_in;
        n_cmp++;
        if (obs !== {e2, exp_tick}) begin
            n_fail++; $display("FAIL sky_first_beat: got %h want %h", obs, {e2, exp_tick});
        end
        drive(11, 10, 1'b1, 1'b1);
        n_cmp++;
        if ({rgb_obs, hs_out, vs_out, blank_out} !== {24'h70C5CE, h0, v0, 1'b1}) begin
            n_fail++;
            $display("FAIL sky_10_10: got %h want %h", {rgb_obs, hs_out, vs_out, blank_out},
                     {24'h70C5CE, h0, v0, 1'b1});
        end
    endtask

    task automatic test_pipe();
        int xs[8] = '{651, 652, 599, 600, 620, 620, 620, 620};
        int ys[8] = '{50, 50, 50, 50, 100, 219, 220, 99};
        bird_y = 10'd200; pipe_x = 11'd600; gap_y = 10'd100;
        drive(0, 480, 1'b0, 1'b1);
        n_cmp++;
        if (frame_tick !== 1'b1) begin
            n_fail++; $display("FAIL pipe_snap_tick: got %b want 1", frame_tick);
        end
        drive(620, 50, 1'b1, 1'b1);
        drive(620, 150, 1'b1, 1'b1);
        n_cmp++;
        if (rgb_obs !== 24'h73BF2E) begin
            n_fail++; $display("FAIL pipe_620_50: got %h want 73bf2e", rgb_obs);
        end
        drive(621, 151, 1'b1, 1'b1);
        n_cmp++;
        if (rgb_obs !== 24'h70C5CE) begin
            n_fail++; $display("FAIL gap_620_150: got %h want 70c5ce", rgb_obs);
        end
        for (int i = 0; i < 10; i++) begin
            if (i < 8) drive(xs[i], ys[i], 1'b1, 1'b1);
            else drive(300, 300, 1'b1, 1'b1);
            n_cmp++;
            if (obs !== {e2, exp_tick}) begin
                n_fail++; $display("FAIL pipe_edges[%0d]: got %h want %h", i, obs, {e2, exp_tick});
            end
        end
        pipe_x = 11'd700;
        drive(0, 480, 1'b0, 1'b1);
        drive(639, 50, 1'b1, 1'b1);
        drive(10, 60, 1'b1, 1'b1);
        n_cmp++;
        if (rgb_obs !== 24'h70C5CE) begin
            n_fail++; $display("FAIL offscreen_pipe_639_50: got %h want 70c5ce", rgb_obs);
        end
    endtask

    task automatic test_bird();
        int xs[7] = '{159, 191, 192, 170, 170, 170, 181};
        int ys[7] = '{210, 210, 210, 199, 223, 224, 206};
        bird_y = 10'd200; pipe_x = 11'd150; gap_y = 10'd300;
        drive(0, 480, 1'b0, 1'b1);
        drive(160, 200, 1'b1, 1'b1);
        drive(170, 210, 1'b1, 1'b1);
        n_cmp++;
        if (rgb_obs !== 24'h73BF2E) begin
            n_fail++; $display("FAIL bird_transparent_over_pipe: got %h want 73bf2e", rgb_obs);
        end
        drive(171, 210, 1'b1, 1'b1);
        n_cmp++;
        if (rgb_obs !== 24'hF8D838) begin
            n_fail++; $display("FAIL bird_opaque_body: got %h want f8d838", rgb_obs);
        end
        pipe_x = 11'd700;
        drive(0, 480, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) begin
            if (i < 7) drive(xs[i], ys[i], 1'b1, 1'b1);
            else drive(160 + i, 200, 1'b1, 1'b1);
            n_cmp++;
            if (obs !== {e2, exp_tick}) begin
                n_fail++; $display("FAIL bird_edges[%0d]: got %h want %h", i, obs, {e2, exp_tick});
            end
        end
    endtask

    task automatic test_snapshot();
        int ticks = 0;
        bird_y = 10'd300;
        for (int i = 0; i < 20; i++) begin
            drive(165 + i, 205 + i, 1'b1, 1'b1);
            n_cmp++;
            if (obs !== {e2, exp_tick}) begin
                n_fail++; $display("FAIL hold_old_shadow[%0d]: got %h want %h", i, obs, {e2, exp_tick});
            end
            if (frame_tick === 1'b1) ticks++;
        end
        drive(170, 210, 1'b1, 1'b1);
        drive(1, 1, 1'b1, 1'b1);
        n_cmp++;
        if (rgb_obs !== 24'hF8D838) begin
            n_fail++; $display("FAIL midframe_change_ignored: got %h want f8d838", rgb_obs);
        end
        bird_y = 10'd260;
        drive(0, 480, 1'b0, 1'b1);
        if (frame_tick === 1'b1) ticks++;
        drive(0, 480, 1'b0, 1'b0);
        if (frame_tick === 1'b1) ticks++;
        bird_y = 10'd400;
        drive(170, 210, 1'b1, 1'b1);
        if (frame_tick === 1'b1) ticks++;
        n_cmp++;
        if (ticks !== 1) begin
            n_fail++; $display("FAIL frame_tick_count: got %0d want 1", ticks);
        end
        drive(170, 270, 1'b1, 1'b1);
        drive(2, 2, 1'b1, 1'b1);
        n_cmp++;
        if (rgb_obs !== 24'hF8D838) begin
            n_fail++; $display("FAIL new_frame_bird_260: got %h want f8d838", rgb_obs);
        end
    endtask

    task automatic test_blank();
        logic [23:0] want;
        drive(700, 10, 1'b0, 1'b1);
        drive(32, 5, 1'b1, 1'b1);
        n_cmp++;
        if ({rgb_obs, blank_out} !== {24'h000000, 1'b0}) begin
            n_fail++; $display("FAIL blank_700_10: got %h want 0000000", {rgb_obs, blank_out});
        end
`ifdef COMPOSITOR_GRID_EN
        want = 24'hFFFFFF;
`else
        want = 24'h70C5CE;
`endif
        drive(40, 6, 1'b1, 1'b1);
        n_cmp++;
        if (rgb_obs !== want) begin
            n_fail++; $display("FAIL grid_32_5: got %h want %h", rgb_obs, want);
        end
    endtask

    task automatic test_random();
        int x, y;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 2))
                    0: bird_y = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(1000, 1023)) : 10'($urandom);
                    1: pipe_x = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(2000, 2047)) : 11'($urandom_range(0, 800));
                    default: gap_y = 10'($urandom_range(0, 460));
                endcase
            end
            case ($urandom_range(0, 2))
                0: begin x = 150 + int'($urandom_range(0, 50)); y = (m_by + int'($urandom_range(0, 30)) - 3) & 1023; end
                1: begin x = (m_px + int'($urandom_range(0, 60)) - 4) & 1023; y = int'($urandom_range(0, 1023)); end
                default: begin x = int'($urandom_range(0, 1023)); y = int'($urandom_range(0, 1023)); end
            endcase
            if (i % 97 == 0) drive(0, 480, 1'b0, 1'b1);
            else drive(x, y, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
            n_cmp++;
            if (obs !== {e2, exp_tick}) begin
                n_fail++; $display("FAIL random[%0d] (%0d,%0d): got %h want %h", i, x, y, obs, {e2, exp_tick});
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) drive(100 + i, 100, 1'b1, 1'b1);
        Reset = 1'b1;
        drive(200, 200, 1'b1, 1'b0);
        n_cmp++;
        if (obs !== {24'h000000, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL reset_midframe_flush: got %h want %h", obs, {24'h000000, 4'b1100});
        end
        Reset = 1'b0;
        drive(170, 250, 1'b1, 1'b1);
        n_cmp++;
        if ({rgb_obs, hs_out, vs_out, blank_out} !== {24'h000000, 1'b1, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL reset_first_beat: got %h want %h", {rgb_obs, hs_out, vs_out, blank_out}, {24'h000000, 3'b110});
        end
        drive(10, 10, 1'b1, 1'b1);
        n_cmp++;
        if ({rgb_obs, blank_out} !== {24'hF8D838, 1'b1}) begin
            n_fail++; $display("FAIL reset_shadow_bird_240: got %h want f8d8381", {rgb_obs, blank_out});
        end
    endtask

    initial begin
        test_reset();
        test_sky();
        test_pipe();
        test_bird();
        test_snapshot();
        test_blank();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
